// File: rtl/timer_driver.sv
// Go/done interval timer initiator: runs N timer periods per request.
// Optional busy-cycle counter enabled by defining TIMER_DRV_PERF_EN.
module timer_driver #(
  parameter int REPEAT_W = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [REPEAT_W-1:0] req_repeat,
  input  logic                cancel,
  output logic                timer_go,
  input  logic                timer_done,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REPEAT_W-1:0] resp_count,
  output logic [1:0]          resp_status,
  output logic [15:0]         resp_cycles
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic [REPEAT_W-1:0] ONE = REPEAT_W'(1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_CAN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    RUN,
    RESP
  } state_t;

  state_t state;
  state_t state_n;

  logic [REPEAT_W-1:0] remaining;
  logic [REPEAT_W-1:0] completed;
  logic [WD_W-1:0]     wd;
  logic                cancel_pending;
  logic [REPEAT_W-1:0] count_q;
  logic [1:0]          status_q;

  logic                go;
  logic                accept;
  logic                busy;
  logic                wd_clr;
  logic                iv_done;
  logic                fin;
  logic [1:0]          fin_status;
  logic [REPEAT_W-1:0] fin_count;

  assign accept = (state == IDLE) && req_valid;
  assign busy   = (state == START) || (state == ARM) || (state == RUN);

  always_comb begin
    state_n    = state;
    go         = 1'b0;
    wd_clr     = 1'b0;
    iv_done    = 1'b0;
    fin        = 1'b0;
    fin_status = ST_OK;
    fin_count  = completed;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_repeat == '0) begin
            state_n   = RESP;
            fin       = 1'b1;
            fin_count = '0;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        if (cancel_pending) begin
          state_n    = RESP;
          fin        = 1'b1;
          fin_status = ST_CAN;
        end else if (timer_done) begin
          go      = 1'b1;
          wd_clr  = 1'b1;
          state_n = ARM;
        end
      end
      ARM: begin
        // Leaving ARM takes priority over a coincident timeout.
        if (!timer_done) begin
          wd_clr  = 1'b1;
          state_n = RUN;
        end else if (wd == WD_MAX) begin
          state_n    = RESP;
          fin        = 1'b1;
          fin_status = ST_TO;
        end
      end
      RUN: begin
        if (timer_done) begin
          iv_done   = 1'b1;
          fin_count = completed + ONE;
          if (remaining == ONE) begin
            state_n = RESP;
            fin     = 1'b1;
          end else if (cancel_pending) begin
            state_n    = RESP;
            fin        = 1'b1;
            fin_status = ST_CAN;
          end else begin
            state_n = START;
          end
        end else if (wd == WD_MAX) begin
          state_n    = RESP;
          fin        = 1'b1;
          fin_status = ST_TO;
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      remaining      <= '0;
      completed      <= '0;
      wd             <= '0;
      cancel_pending <= 1'b0;
      count_q        <= '0;
      status_q       <= ST_OK;
    end else begin
      state <= state_n;
      if (accept) begin
        remaining <= req_repeat;
        completed <= '0;
      end else if (iv_done) begin
        remaining <= remaining - ONE;
        completed <= completed + ONE;
      end
      if (wd_clr) begin
        wd <= '0;
      end else if ((state == ARM) || (state == RUN)) begin
        wd <= wd + WD_W'(1);
      end
      if ((state == RESP) && resp_ready) begin
        cancel_pending <= 1'b0;
      end else if (busy && cancel) begin
        cancel_pending <= 1'b1;
      end
      if (fin) begin
        count_q  <= fin_count;
        status_q <= fin_status;
      end
    end
  end

`ifdef TIMER_DRV_PERF_EN
  logic [15:0] perf;
  logic [15:0] perf_inc;
  logic [15:0] cycles_q;

  assign perf_inc = (perf == 16'hFFFF) ? perf : perf + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf     <= '0;
      cycles_q <= '0;
    end else begin
      if (accept) begin
        perf <= '0;
      end else if (busy) begin
        perf <= perf_inc;
      end
      // The RESP-entry cycle is itself busy, so it is included.
      if (fin) cycles_q <= busy ? perf_inc : 16'd0;
    end
  end

  assign resp_cycles = cycles_q;
`else
  assign resp_cycles = '0;
`endif

  assign req_ready   = (state == IDLE);
  assign timer_go    = go && !rst;
  assign resp_valid  = (state == RESP);
  assign resp_count  = count_q;
  assign resp_status = status_q;

endmodule

// File: doc/timer_driver.md
Name: timer_driver

Overview:
Initiator-side controller for the go/done interval timer. It accepts a request on a valid/ready handshake and issues back-to-back one-cycle go pulses to one external timer instance, one pulse per interval. It tracks the timer's done level to count completed intervals and guards each phase with a watchdog. It reports a count plus status on a valid/ready response channel, so sequencers can chain N timer periods without handling the timer protocol themselves.

Parameters:
REPEAT_W, 8, width of request repeat count and response count
TIMEOUT, 64, watchdog limit in cycles per wait phase (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; also drives the attached timer's rst
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_repeat  in  REPEAT_W  number of timer intervals to run
cancel  in  1  level; stop after current interval
timer_go  out  1  go to timer, single-cycle pulse
timer_done  in  1  timer done (high while idle, high on last active cycle)
resp_valid  out  1  response present, held until accepted
resp_ready  in  1  response consumed when valid&ready
resp_count  out  REPEAT_W  intervals completed
resp_status  out  2  00 OK, 01 TIMEOUT, 10 CANCELLED
resp_cycles  out  16  busy-cycle count (see Optional Feature)

Behaviour:
- Reset values: state IDLE, req_ready=1, timer_go=0, resp_valid=0, resp_count=0, resp_status=00, resp_cycles=0, all internal counters 0, cancel_pending=0.
- States: IDLE, START, ARM, RUN, RESP. Watchdog wd (clog2(TIMEOUT) bits) clears on entry to ARM and RUN and increments each cycle in those states.
- IDLE: req_ready=1. On req_valid, latch remaining=req_repeat and clear completed. If req_repeat==0, go to RESP with OK and count 0; otherwise go to START. req_ready=0 in all other states.
- START: if cancel_pending, go to RESP with CANCELLED. Otherwise, if timer_done==1, assert timer_go for this cycle only and go to ARM. If timer_done==0, hold with go=0.
- ARM: timer_done==0 -> RUN. Otherwise, when wd==TIMEOUT-1 -> RESP with TIMEOUT. The exit condition wins over the timeout in the same cycle.
- RUN: timer_done==1 completes an interval: completed+1, remaining-1. If remaining becomes 0 -> RESP OK. Else if cancel_pending -> RESP CANCELLED. Else -> START. Otherwise, when wd==TIMEOUT-1 -> RESP with TIMEOUT.
- A done level seen high in RUN is counted once only; the next state never re-samples it as a completion.
- cancel: sampled in START/ARM/RUN and sets the sticky cancel_pending. The in-flight interval always finishes, because the timer cannot be stopped. cancel_pending clears on entry to IDLE. cancel in IDLE is ignored.
- RESP: resp_valid=1. resp_count/resp_status are registered and stable until resp_ready; valid&ready -> IDLE. The next request can be accepted no earlier than the cycle after the handshake.
- Arithmetic: counters are REPEAT_W-bit unsigned. completed never exceeds req_repeat, so no wrap.
- Per-interval cost with a CYCLES-period timer: 1 START cycle + CYCLES cycles. The first go is issued the cycle after acceptance.
- rst mid-operation: immediate return to reset values. Any pending response is discarded and no go is issued in the reset cycle.

Optional Feature:
Macro TIMER_DRV_PERF_EN.
- Defined: a 16-bit saturating counter clears on request acceptance and increments every cycle in START/ARM/RUN. It is copied to resp_cycles on RESP entry and holds 0xFFFF on saturation.
- Undefined: resp_cycles is tied to 0 and the counter logic is absent.

Test Plan:
- Timer CYCLES=4, req_repeat=3, accepted at cycle 0 -> go pulses at cycles 1, 6, 11; RESP entered cycle 16 with resp_count=3, status 00; resp_cycles=15 with TIMER_DRV_PERF_EN, 0 without.
- req_repeat=0 -> no timer_go ever; resp_valid the cycle after acceptance, count 0, status 00.
- timer_done stuck high, TIMEOUT=8, req_repeat=2 -> one go pulse, 8 ARM cycles, RESP with status 01, count 0. Repeat with done stuck low in RUN -> status 01, count 0.
- CYCLES=4, req_repeat=5, cancel pulsed one cycle during the 2nd interval -> 2nd interval completes, no 3rd go; RESP status 10, count 2.
- resp_ready held low 10 cycles -> resp_valid/count/status stable throughout; a new req_valid stays un-accepted until the cycle after the response handshake.
- rst asserted during RUN of interval 2 -> the next cycle shows timer_go=0, resp_valid=0, req_ready=1; a following request (repeat=1) completes normally with count 1.
